// File: rtl/t05_pkg.sv
// Shared types for the SPI byte reader: FSM state encoding and the flash READ opcode.
package t05_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_STOP
    } t05_spi_state_t;

    localparam logic [7:0] T05_CMD_READ = 8'h03;

endpackage

// File: rtl/t05_spi_byte_fifo.sv
// Synchronous byte FIFO feeding the decoder; the head output holds the last popped byte while empty.
module t05_spi_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [7:0]       i_din,
    input  logic             i_pop,
    output logic [7:0]       o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_last;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[r_rd_ptr];
            end
            r_count <= r_count + {{(CNT_W-1){1'b0}}, w_do_push} - {{(CNT_W-1){1'b0}}, w_do_pop};
        end
    end

    assign o_head  = w_empty ? r_last : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/t05_spi_byte_reader.sv
// SPI mode-0 master issuing a flash READ and streaming bytes into a prefetch FIFO.
// Optional macro T05_SPI_BYTE_COUNT_EN adds the saturating bytes_popped counter port.
module t05_spi_byte_reader
    import t05_pkg::*;
#(
    parameter int          CLK_DIV    = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_W     = 24,
    parameter logic [7:0]  CMD_READ   = T05_CMD_READ
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              read_en,
    output logic [7:0]        data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
`ifdef T05_SPI_BYTE_COUNT_EN
    ,
    output logic [31:0]       bytes_popped
`endif
);

    localparam int SH_W  = 8 + ADDR_W;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(ADDR_W) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    t05_spi_state_t   r_state;
    t05_spi_state_t   w_state_nxt;
    logic             r_en_q;
    logic [DIV_W-1:0] r_div;
    logic [BIT_W-1:0] r_bit;
    logic             r_sclk;
    logic             r_cs_n;
    logic [SH_W-1:0]  r_tx;
    logic [6:0]       r_rx;

    logic             w_en_rise;
    logic             w_start;
    logic             w_active;
    logic             w_pause;
    logic             w_div_end;
    logic             w_tick;
    logic             w_rise;
    logic             w_fall;
    logic             w_last_bit;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_din;
    logic [7:0]       w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;

    assign w_en_rise = enable & ~r_en_q;
    assign w_start   = (r_state == ST_IDLE) & w_en_rise;
    assign w_active  = enable & ((r_state == ST_CMD) | (r_state == ST_ADDR) | (r_state == ST_DATA));
    // Hold SCLK low before starting a byte that would have no FIFO slot to land in.
    assign w_pause   = (r_state == ST_DATA) & ~r_sclk & (r_bit == '0) & w_full;
    assign w_div_end = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_tick    = w_active & ~w_pause & w_div_end;
    assign w_rise    = w_tick & ~r_sclk;
    assign w_fall    = w_tick & r_sclk;
    assign w_din     = {r_rx, spi_miso};
    assign w_push    = (r_state == ST_DATA) & w_rise & (r_bit == BIT_W'(7));
    assign w_pop     = read_en & data_valid;

    always_comb begin
        w_last_bit = 1'b0;
        case (r_state)
            ST_CMD:  w_last_bit = (r_bit == BIT_W'(7));
            ST_ADDR: w_last_bit = (r_bit == BIT_W'(ADDR_W - 1));
            ST_DATA: w_last_bit = (r_bit == BIT_W'(7));
            default: w_last_bit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_en_rise) w_state_nxt = ST_CMD;
            ST_CMD: begin
                if (!enable)                  w_state_nxt = ST_STOP;
                else if (w_fall && w_last_bit) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (!enable)                  w_state_nxt = ST_STOP;
                else if (w_fall && w_last_bit) w_state_nxt = ST_DATA;
            end
            ST_DATA: if (!enable)   w_state_nxt = ST_STOP;
            ST_STOP: if (w_div_end) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tracks enable even through reset so a level held high across reset is not seen as a new rise.
    always_ff @(posedge clk) begin
        r_en_q <= enable;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cs_n <= 1'b1;
            r_sclk <= 1'b0;
            r_div  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
        end else if (w_start) begin
            r_cs_n <= 1'b0;
            r_sclk <= 1'b0;
            r_div  <= '0;
            r_bit  <= '0;
            r_tx   <= {CMD_READ, start_addr};
        end else if (r_state == ST_STOP) begin
            r_div <= w_div_end ? '0 : r_div + 1'b1;
        end else if (r_state != ST_IDLE && !enable) begin
            r_cs_n <= 1'b1;
            r_sclk <= 1'b0;
            r_div  <= '0;
            r_bit  <= '0;
            r_tx   <= '0;
        end else if (w_active) begin
            r_div <= (w_pause || w_div_end) ? '0 : r_div + 1'b1;
            if (w_rise) begin
                r_sclk <= 1'b1;
                r_rx   <= w_din[6:0];
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_tx   <= {r_tx[SH_W-2:0], 1'b0};
                r_bit  <= w_last_bit ? '0 : r_bit + 1'b1;
            end
        end
    end

    t05_spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (read_en),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

`ifdef T05_SPI_BYTE_COUNT_EN
    logic [31:0] r_bytes_popped;

    always_ff @(posedge clk) begin
        if (!rst || w_start) begin
            r_bytes_popped <= '0;
        end else if (w_pop && (r_bytes_popped != '1)) begin
            r_bytes_popped <= r_bytes_popped + 1'b1;
        end
    end

    assign bytes_popped = r_bytes_popped;
`endif

    assign data_out   = w_head;
    assign data_valid = (w_count != '0);
    assign busy       = (r_state != ST_IDLE);
    assign spi_sclk   = r_sclk;
    assign spi_cs_n   = r_cs_n;
    assign spi_mosi   = r_tx[SH_W-1];

endmodule

// File: tb/tb_t05_spi_byte_reader.sv
// Directed bench for t05_spi_byte_reader with a behavioural serial-flash model on the SPI pins.
module tb_t05_spi_byte_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [23:0] start_addr = '0;
    logic        read_en = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        busy;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;
`ifdef T05_SPI_BYTE_COUNT_EN
    logic [31:0] bytes_popped;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    t05_spi_byte_reader #(
        .CLK_DIV    (2),
        .FIFO_DEPTH (4),
        .ADDR_W     (24),
        .CMD_READ   (8'h03)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start_addr (start_addr),
        .read_en    (read_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .busy       (busy),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso)
`ifdef T05_SPI_BYTE_COUNT_EN
        ,
        .bytes_popped (bytes_popped)
`endif
    );

    // Flash contents: three fixed bytes at 0x100, then an arithmetic pattern.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        logic [23:0] k;
        k = a - 24'h000100;
        case (k)
            24'd0:   return 8'hA5;
            24'd1:   return 8'h3C;
            24'd2:   return 8'h7E;
            default: return k[7:0] * 8'd29 + 8'd17;
        endcase
    endfunction

    logic [31:0] m_hdr = '0;
    int          m_bits = 0;
    int          m_rises = 0;

    always @(posedge spi_sclk or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            m_bits <= 0;
        end else begin
            m_rises <= m_rises + 1;
            m_bits  <= m_bits + 1;
            if (m_bits < 32) m_hdr <= {m_hdr[30:0], spi_mosi};
        end
    end

    always @(negedge spi_sclk) begin
        if (m_bits >= 32) begin
            logic [7:0] b;
            int idx;
            idx = m_bits - 32;
            b = flash_byte(m_hdr[23:0] + 24'(idx / 8));
            spi_miso <= b[7 - (idx % 8)];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop();
        read_en = 1'b1;
        tick(1);
        read_en = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (data_valid !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check(tag, {31'b0, data_valid}, 32'd1);
    endtask

    task automatic wait_rises(input string tag, input int target);
        int n;
        n = 0;
        while (m_rises < target && n < 400) begin
            tick(1);
            n++;
        end
        check(tag, m_rises, target);
    endtask

    initial begin
        int rb;
        int rr;

        // Reset values
        tick(3);
        rst = 1'b1;
        check("rst_cs_n", {31'b0, spi_cs_n}, 32'd1);
        check("rst_sclk", {31'b0, spi_sclk}, 32'd0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'd0);
        check("rst_valid", {31'b0, data_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_data_out", {24'b0, data_out}, 32'd0);

        // Pop on empty is ignored
        pop();
        check("underflow_valid", {31'b0, data_valid}, 32'd0);
        check("underflow_data", {24'b0, data_out}, 32'd0);

        // Header and first bytes
        rb = m_rises;
        start_addr = 24'h000100;
        enable = 1'b1;
        wait_rises("hdr_rises", rb + 32);
        check("hdr_bits", m_hdr, 32'h0300_0100);
        check("hdr_cs_low", {31'b0, spi_cs_n}, 32'd0);
        wait_valid("first_valid");
        check("first_byte", {24'b0, data_out}, 32'hA5);

        // Backpressure: no pops, FIFO fills with exactly four bytes and SCLK stops
        tick(200);
        check("bp_rises", m_rises - rb, 32'd64);
        rr = m_rises;
        tick(40);
        check("bp_no_edges", m_rises, rr);
        check("bp_sclk", {31'b0, spi_sclk}, 32'd0);
        check("bp_cs_n", {31'b0, spi_cs_n}, 32'd0);
        check("bp_busy", {31'b0, busy}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            wait_valid($sformatf("pop_valid_%0d", i));
            check($sformatf("pop_byte_%0d", i), {24'b0, data_out}, {24'b0, flash_byte(24'h100 + 24'(i))});
            pop();
        end

        // Abort mid-byte: partial byte must not appear in the FIFO
        tick(200);
        check("ab_head", {24'b0, data_out}, {24'b0, flash_byte(24'h10A)});
        pop();
        rb = m_rises;
        wait_rises("ab_mid", rb + 3);
        enable = 1'b0;
        tick(1);
        check("ab_cs_n0", {31'b0, spi_cs_n}, 32'd1);
        check("ab_sclk0", {31'b0, spi_sclk}, 32'd0);
        check("ab_busy0", {31'b0, busy}, 32'd1);
        tick(1);
        check("ab_cs_n1", {31'b0, spi_cs_n}, 32'd1);
        check("ab_busy1", {31'b0, busy}, 32'd1);
        tick(1);
        check("ab_busy2", {31'b0, busy}, 32'd0);
        for (int i = 11; i < 14; i++) begin
            check($sformatf("ab_valid_%0d", i), {31'b0, data_valid}, 32'd1);
            check($sformatf("ab_byte_%0d", i), {24'b0, data_out}, {24'b0, flash_byte(24'h100 + 24'(i))});
            pop();
        end
        check("ab_empty", {31'b0, data_valid}, 32'd0);
        check("ab_hold", {24'b0, data_out}, {24'b0, flash_byte(24'h10D)});
        pop();
        check("ab_uf_valid", {31'b0, data_valid}, 32'd0);
        check("ab_uf_hold", {24'b0, data_out}, {24'b0, flash_byte(24'h10D)});

        // Reset in the middle of a data byte
        enable = 1'b1;
        wait_valid("rs_valid");
        tick(10);
        rst = 1'b0;
        tick(1);
        check("rs_cs_n", {31'b0, spi_cs_n}, 32'd1);
        check("rs_sclk", {31'b0, spi_sclk}, 32'd0);
        check("rs_valid0", {31'b0, data_valid}, 32'd0);
        check("rs_busy", {31'b0, busy}, 32'd0);
        tick(2);
        rst = 1'b1;
        rb = m_rises;
        tick(40);
        check("rs_no_edges", m_rises, rb);
        check("rs_sclk_idle", {31'b0, spi_sclk}, 32'd0);
        check("rs_cs_idle", {31'b0, spi_cs_n}, 32'd1);
`ifdef T05_SPI_BYTE_COUNT_EN
        check("cnt_after_rst", bytes_popped, 32'd0);
`endif
        enable = 1'b0;
        tick(2);

        // Pop counting: two ignored pops, five accepted
        enable = 1'b1;
        tick(1);
        pop();
        pop();
        for (int i = 0; i < 5; i++) begin
            wait_valid($sformatf("cnt_valid_%0d", i));
            check($sformatf("cnt_byte_%0d", i), {24'b0, data_out}, {24'b0, flash_byte(24'h100 + 24'(i))});
            pop();
        end
`ifdef T05_SPI_BYTE_COUNT_EN
        check("cnt_five", bytes_popped, 32'd5);
`endif

        // FIFO contents survive STOP, then a new enable rise flushes them
        tick(200);
        enable = 1'b0;
        tick(5);
        check("keep_valid", {31'b0, data_valid}, 32'd1);
        check("keep_head", {24'b0, data_out}, {24'b0, flash_byte(24'h105)});
        enable = 1'b1;
        tick(1);
        check("flush_valid", {31'b0, data_valid}, 32'd0);
        check("flush_busy", {31'b0, busy}, 32'd1);
`ifdef T05_SPI_BYTE_COUNT_EN
        check("cnt_clear", bytes_popped, 32'd0);
`endif
        enable = 1'b0;
        tick(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
